// File: rtl/vga_video_pipe_pkg.sv
// Shared definitions for the VGA video pipe: VESA mode presets, default
// widths, the stage-0 flag bundle carried through the latency-matching
// delay line, and small elaboration-time helpers.
package vga_video_pipe_pkg;

  // Default datapath widths and the deepest supported pixel-source latency
  localparam int unsigned DEF_CW    = 1;
  localparam int unsigned DEF_CNT_W = 11;
  localparam int unsigned MAX_LAT   = 4;

  // 640x480 @ 60 Hz (25.175 MHz), negative syncs
  localparam int unsigned M640_H_ACTIVE = 640;
  localparam int unsigned M640_H_FP     = 16;
  localparam int unsigned M640_H_SYNC   = 96;
  localparam int unsigned M640_H_BP     = 48;
  localparam int unsigned M640_V_ACTIVE = 480;
  localparam int unsigned M640_V_FP     = 10;
  localparam int unsigned M640_V_SYNC   = 2;
  localparam int unsigned M640_V_BP     = 33;
  localparam int unsigned M640_HS_POL   = 0;
  localparam int unsigned M640_VS_POL   = 0;

  // 800x600 @ 60 Hz (40 MHz), positive syncs
  localparam int unsigned M800_H_ACTIVE = 800;
  localparam int unsigned M800_H_FP     = 40;
  localparam int unsigned M800_H_SYNC   = 128;
  localparam int unsigned M800_H_BP     = 88;
  localparam int unsigned M800_V_ACTIVE = 600;
  localparam int unsigned M800_V_FP     = 1;
  localparam int unsigned M800_V_SYNC   = 4;
  localparam int unsigned M800_V_BP     = 23;
  localparam int unsigned M800_HS_POL   = 1;
  localparam int unsigned M800_VS_POL   = 1;

  // 1024x768 @ 60 Hz (65 MHz), negative syncs
  localparam int unsigned M1024_H_ACTIVE = 1024;
  localparam int unsigned M1024_H_FP     = 24;
  localparam int unsigned M1024_H_SYNC   = 136;
  localparam int unsigned M1024_H_BP     = 160;
  localparam int unsigned M1024_V_ACTIVE = 768;
  localparam int unsigned M1024_V_FP     = 3;
  localparam int unsigned M1024_V_SYNC   = 6;
  localparam int unsigned M1024_V_BP     = 29;
  localparam int unsigned M1024_HS_POL   = 0;
  localparam int unsigned M1024_VS_POL   = 0;

  // Timing flags generated alongside each request; hs/vs are "inside the
  // sync window", polarity is applied only at the pad register
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic fs;
    logic ls;
  } vga_flags_t;

  localparam int unsigned FLAGS_W = $bits(vga_flags_t);

  // Clocks per line / lines per frame
  function automatic int unsigned span_total(input int unsigned active,
                                             input int unsigned fp,
                                             input int unsigned sync,
                                             input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // True when a counter of width w can hold total-1
  function automatic bit cnt_fits(input int unsigned total, input int unsigned w);
    return (64'(total) - 64'd1) < (64'd1 << w);
  endfunction

endpackage

// File: rtl/vga_video_pipe_delay_line.sv
// vga_delay_line: DEPTH-stage register pipeline with async active-low reset.
// DEPTH=0 degenerates to a wire.
//   clk    : pixel clock
//   rst_n  : asynchronous active-low reset, loads RESET_VAL into every stage
//   d_i    : WIDTH-bit input
//   q_o    : d_i delayed by DEPTH clocks
module vga_delay_line #(
  parameter int unsigned       WIDTH     = 1,
  parameter int unsigned       DEPTH     = 1,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    // Clock and reset are idle in the pass-through configuration
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift register, stage 0 nearest the input
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= RESET_VAL;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_video_pipe.sv
// vga_video_pipe: parametrised VGA raster generator. Issues (x,y) pixel
// requests to a frame source, then delays sync/de/start flags by the source
// latency so returned pixels and syncs reach the pads on the same clock.
//   clk, rst_n           : pixel clock, async active-low reset
//   en                   : timing enable; low parks the raster at (0,0)
//   req_valid/x/y        : registered fetch request for an active pixel
//   pix_r/g/b            : source data, valid LAT clocks after the request
//   red/green/blue       : pad colour, forced to 0 outside the active area
//   hsync/vsync          : pad syncs with HS_POL/VS_POL active level
//   de                   : data enable aligned with colour
//   frame_start          : one-clock pulse with output pixel (0,0)
//   line_start           : one-clock pulse with output pixel x=0 of active lines
module vga_video_pipe
  import vga_video_pipe_pkg::*;
#(
  parameter int unsigned H_ACTIVE = M800_H_ACTIVE,
  parameter int unsigned H_FP     = M800_H_FP,
  parameter int unsigned H_SYNC   = M800_H_SYNC,
  parameter int unsigned H_BP     = M800_H_BP,
  parameter int unsigned V_ACTIVE = M800_V_ACTIVE,
  parameter int unsigned V_FP     = M800_V_FP,
  parameter int unsigned V_SYNC   = M800_V_SYNC,
  parameter int unsigned V_BP     = M800_V_BP,
  parameter int unsigned HS_POL   = M800_HS_POL,
  parameter int unsigned VS_POL   = M800_VS_POL,
  parameter int unsigned CW       = DEF_CW,
  parameter int unsigned LAT      = 1,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic             req_valid,
  output logic [CNT_W-1:0] req_x,
  output logic [CNT_W-1:0] req_y,
  input  logic [CW-1:0]    pix_r,
  input  logic [CW-1:0]    pix_g,
  input  logic [CW-1:0]    pix_b,
  output logic [CW-1:0]    red,
  output logic [CW-1:0]    green,
  output logic [CW-1:0]    blue,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic             frame_start,
  output logic             line_start
);

  localparam int unsigned H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam logic        HS_ACT   = 1'(HS_POL);
  localparam logic        VS_ACT   = 1'(VS_POL);

  // Parameter sanity, caught at elaboration
  if (LAT > MAX_LAT) begin : g_bad_lat
    $error("vga_video_pipe: LAT=%0d exceeds maximum %0d", LAT, MAX_LAT);
  end
  if (!cnt_fits(H_TOTAL, CNT_W) || !cnt_fits(V_TOTAL, CNT_W)) begin : g_bad_cnt_w
    $error("vga_video_pipe: CNT_W=%0d cannot hold H_TOTAL=%0d / V_TOTAL=%0d",
           CNT_W, H_TOTAL, V_TOTAL);
  end

  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] vcnt_q, vcnt_d;
  logic             active_c, hs_c, vs_c;

  logic             req_valid_q, req_valid_d;
  logic [CNT_W-1:0] req_x_q, req_x_d;
  logic [CNT_W-1:0] req_y_q, req_y_d;
  vga_flags_t       flags0_q, flags0_d;
  vga_flags_t       flags_lat;

  logic [CW-1:0]    red_q, red_d;
  logic [CW-1:0]    green_q, green_d;
  logic [CW-1:0]    blue_q, blue_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             de_q, de_d;
  logic             fs_q, fs_d;
  logic             ls_q, ls_d;

  // Region decode of the current raster position (compared at 32 bits so
  // window ends equal to the total never need to fit in CNT_W)
  always_comb begin
    active_c = (32'(hcnt_q) < H_ACTIVE) && (32'(vcnt_q) < V_ACTIVE);
    hs_c     = (32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END);
    vs_c     = (32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END);
  end

  // Raster counters; explicit wrap compares, never modular overflow
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (!en) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (32'(hcnt_q) == H_TOTAL - 1) begin
      hcnt_d = '0;
      if (32'(vcnt_q) == V_TOTAL - 1) vcnt_d = '0;
      else                            vcnt_d = vcnt_q + CNT_W'(1);
    end else begin
      hcnt_d = hcnt_q + CNT_W'(1);
    end
  end

  // Stage 0: request plus the timing flags that travel with it
  always_comb begin
    req_valid_d = 1'b0;
    req_x_d     = '0;
    req_y_d     = '0;
    flags0_d    = '0;
    if (en) begin
      req_valid_d = active_c;
      if (active_c) begin
        req_x_d = hcnt_q;
        req_y_d = vcnt_q;
      end
      flags0_d.hs = hs_c;
      flags0_d.vs = vs_c;
      flags0_d.de = active_c;
      flags0_d.fs = active_c && (hcnt_q == '0) && (vcnt_q == '0);
      flags0_d.ls = active_c && (hcnt_q == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      req_valid_q <= 1'b0;
      req_x_q     <= '0;
      req_y_q     <= '0;
      flags0_q    <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      req_valid_q <= req_valid_d;
      req_x_q     <= req_x_d;
      req_y_q     <= req_y_d;
      flags0_q    <= flags0_d;
    end
  end

  // Match the flags to the pixel-source latency
  vga_delay_line #(
    .WIDTH     (FLAGS_W),
    .DEPTH     (LAT),
    .RESET_VAL ('0)
  ) u_flag_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (flags0_q),
    .q_o   (flags_lat)
  );

  // Pad register: blank colour outside the active area, apply sync polarity
  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (flags_lat.de) begin
      red_d   = pix_r;
      green_d = pix_g;
      blue_d  = pix_b;
    end
    hsync_d = flags_lat.hs ? HS_ACT : ~HS_ACT;
    vsync_d = flags_lat.vs ? VS_ACT : ~VS_ACT;
    de_d    = flags_lat.de;
    fs_d    = flags_lat.fs;
    ls_d    = flags_lat.ls;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= ~HS_ACT;
      vsync_q <= ~VS_ACT;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      ls_q    <= 1'b0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      ls_q    <= ls_d;
    end
  end

  assign req_valid   = req_valid_q;
  assign req_x       = req_x_q;
  assign req_y       = req_y_q;
  assign red         = red_q;
  assign green       = green_q;
  assign blue        = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule

// File: tb/tb_vga_video_pipe.sv
// Bench for vga_video_pipe on a tiny 8x6 raster: one instance with LAT=2 and
// positive syncs, one with LAT=0 and negative syncs, sharing clk/rst_n/en.
`timescale 1ns/1ps
module tb_vga_video_pipe;

  localparam int HA = 4, HF = 1, HSW = 2, HB = 1;
  localparam int VA = 3, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;   // 8
  localparam int VT = VA + VF + VSW + VB;   // 6
  localparam int LAT0 = 2, LAT1 = 0;

  typedef struct packed {
    logic       rv;
    logic [3:0] x;
    logic [3:0] y;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       ls;
  } mreq_t;

  typedef struct packed {
    logic r, g, b, hs, vs, de, fs, ls;
  } pad_t;

  typedef struct packed {
    logic       v;
    logic [3:0] x;
    logic [3:0] y;
  } src_t;

  typedef struct {
    logic rst_n;
    logic en;
    int   cycles;
    int   fs0, ls0, de0, fs1, ls1, de1;
  } phase_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;

  logic       rv0, rv1;
  logic [3:0] rx0, ry0, rx1, ry1;
  logic       pr0, pg0, pb0, pr1, pg1, pb1;
  logic       r0, g0, b0, hs0, vs0, de0, fs0, ls0;
  logic       r1, g1, b1, hs1, vs1, de1, fs1, ls1;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_fs0, n_ls0, n_de0, n_fs1, n_ls1, n_de1;

  always #5 clk = ~clk;

  vga_video_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1), .VS_POL(1), .CW(1), .LAT(LAT0), .CNT_W(4)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(rv0), .req_x(rx0), .req_y(ry0),
    .pix_r(pr0), .pix_g(pg0), .pix_b(pb0),
    .red(r0), .green(g0), .blue(b0),
    .hsync(hs0), .vsync(vs0), .de(de0),
    .frame_start(fs0), .line_start(ls0)
  );

  vga_video_pipe #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(0), .CW(1), .LAT(LAT1), .CNT_W(4)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(rv1), .req_x(rx1), .req_y(ry1),
    .pix_r(pr1), .pix_g(pg1), .pix_b(pb1),
    .red(r1), .green(g1), .blue(b1),
    .hsync(hs1), .vsync(vs1), .de(de1),
    .frame_start(fs1), .line_start(ls1)
  );

  // Pixel sources: pattern r=x[0], g=y[0], b=x[1]; all-ones when no request
  // so any leak of source data into blanking shows up
  src_t s1 = '0, s2 = '0;
  always @(posedge clk) begin
    s1 <= '{v: rv0, x: rx0, y: ry0};
    s2 <= s1;
  end
  assign pr0 = s2.v ? s2.x[0] : 1'b1;
  assign pg0 = s2.v ? s2.y[0] : 1'b1;
  assign pb0 = s2.v ? s2.x[1] : 1'b1;
  assign pr1 = rv1 ? rx1[0] : 1'b1;
  assign pg1 = rv1 ? ry1[0] : 1'b1;
  assign pb1 = rv1 ? rx1[1] : 1'b1;

  // Reference raster model
  function automatic mreq_t model_req(input int h, input int v);
    mreq_t m;
    logic  act;
    act  = (h < HA) && (v < VA);
    m.rv = act;
    m.x  = act ? 4'(h) : 4'd0;
    m.y  = act ? 4'(v) : 4'd0;
    m.hs = (h >= HA + HF) && (h < HA + HF + HSW);
    m.vs = (v >= VA + VF) && (v < VA + VF + VSW);
    m.fs = act && (h == 0) && (v == 0);
    m.ls = act && (h == 0);
    return m;
  endfunction

  function automatic pad_t exp_pad(input mreq_t m, input logic hp, input logic vp);
    pad_t p;
    p.r  = m.rv & m.x[0];
    p.g  = m.rv & m.y[0];
    p.b  = m.rv & m.x[1];
    p.hs = m.hs ? hp : ~hp;
    p.vs = m.vs ? vp : ~vp;
    p.de = m.rv;
    p.fs = m.fs;
    p.ls = m.ls;
    return p;
  endfunction

  mreq_t m_req;
  int    m_h, m_v;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_req <= '0; m_h <= 0; m_v <= 0;
    end else if (!en) begin
      m_req <= '0; m_h <= 0; m_v <= 0;
    end else begin
      m_req <= model_req(m_h, m_v);
      if (m_h == HT - 1) begin
        m_h <= 0;
        m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end
  end

  pad_t q0[$], q1[$];
  pad_t idle0, idle1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  // Scoreboard step, called once per clock at the falling edge
  task automatic sb_step();
    pad_t a0, a1, e0, e1;
    cyc++;
    a0 = {r0, g0, b0, hs0, vs0, de0, fs0, ls0};
    a1 = {r1, g1, b1, hs1, vs1, de1, fs1, ls1};
    n_fs0 += int'(fs0); n_ls0 += int'(ls0); n_de0 += int'(de0);
    n_fs1 += int'(fs1); n_ls1 += int'(ls1); n_de1 += int'(de1);
    if (!rst_n) begin
      q0.delete(); q1.delete();
      for (int i = 0; i <= LAT0; i++) q0.push_back(idle0);
      for (int i = 0; i <= LAT1; i++) q1.push_back(idle1);
      chk("pad0_reset", 32'(a0), 32'(idle0));
      chk("pad1_reset", 32'(a1), 32'(idle1));
      chk("req0_reset", {rv0, rx0, ry0}, 32'd0);
    end else begin
      chk("req0", {rv0, rx0, ry0}, {m_req.rv, m_req.x, m_req.y});
      chk("req1", {rv1, rx1, ry1}, {m_req.rv, m_req.x, m_req.y});
      q0.push_back(exp_pad(m_req, 1'b1, 1'b1));
      q1.push_back(exp_pad(m_req, 1'b0, 1'b0));
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      chk("pad0", 32'(a0), 32'(e0));
      chk("pad1", 32'(a1), 32'(e1));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    sb_step();
  endtask

  phase_t tbl[4];

  initial begin
    idle0 = exp_pad('0, 1'b1, 1'b1);
    idle1 = exp_pad('0, 1'b0, 1'b0);

    // {rst_n, en, cycles, dut0 fs/ls/de pulses, dut1 fs/ls/de pulses}
    tbl[0] = '{1'b0, 1'b0,   3, 0, 0,  0, 0, 0,  0};
    tbl[1] = '{1'b1, 1'b1,  11, 1, 1,  4, 1, 2,  6};  // ends with req (2,1)
    tbl[2] = '{1'b1, 1'b0,  10, 0, 1,  3, 0, 0,  1};  // en low: drain
    tbl[3] = '{1'b1, 1'b1, 110, 3, 8, 31, 3, 8, 32};  // restart from (0,0)

    for (int p = 0; p < 4; p++) begin
      rst_n = tbl[p].rst_n;
      en    = tbl[p].en;
      n_fs0 = 0; n_ls0 = 0; n_de0 = 0; n_fs1 = 0; n_ls1 = 0; n_de1 = 0;
      for (int c = 0; c < tbl[p].cycles; c++) tick();
      chk($sformatf("ph%0d_fs0", p), 32'(n_fs0), 32'(tbl[p].fs0));
      chk($sformatf("ph%0d_ls0", p), 32'(n_ls0), 32'(tbl[p].ls0));
      chk($sformatf("ph%0d_de0", p), 32'(n_de0), 32'(tbl[p].de0));
      chk($sformatf("ph%0d_fs1", p), 32'(n_fs1), 32'(tbl[p].fs1));
      chk($sformatf("ph%0d_ls1", p), 32'(n_ls1), 32'(tbl[p].ls1));
      chk($sformatf("ph%0d_de1", p), 32'(n_de1), 32'(tbl[p].de1));
    end

    // Async reset mid-line, while dut0 is driving an active pixel
    chk("pre_reset_de0", 32'(de0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_pad0", 32'({r0, g0, b0, hs0, vs0, de0, fs0, ls0}), 32'(idle0));
    chk("async_pad1", 32'({r1, g1, b1, hs1, vs1, de1, fs1, ls1}), 32'(idle1));
    chk("async_req0", {rv0, rx0, ry0}, 32'd0);
    chk("async_req1", {rv1, rx1, ry1}, 32'd0);
    tick();
    tick();

    // Release: the first edge must issue request (0,0)
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("first_req0", {rv0, rx0, ry0}, {1'b1, 4'd0, 4'd0});
    chk("first_req1", {rv1, rx1, ry1}, {1'b1, 4'd0, 4'd0});
    @(negedge clk);
    sb_step();
    n_fs0 = 0; n_fs1 = 0;
    for (int c = 0; c < 60; c++) tick();
    chk("post_reset_fs0", 32'(n_fs0), 32'd2);
    chk("post_reset_fs1", 32'(n_fs1), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_video_pipe.md
Name: vga_video_pipe

Overview:
- Parametrised successor to the fixed 800x600 driver: one block generates H/V timing, pixel fetch requests, and aligned RGB output for any VESA-style mode.
- Sync polarity, colour depth, and pixel-source latency are parameters.
- Issues (x,y) requests to a frame/colour memory and delays hsync/vsync/de so that returned pixel data lines up with sync at the pins.
- Sits between the clock divider and the pads; replaces the separate sync-timing and driver counter logic.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (clocks)
H_SYNC, 128, hsync width (clocks)
H_BP, 88, horizontal back porch (clocks)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vsync width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
CW, 1, bits per colour channel
LAT, 1, pixel-source read latency in clocks, legal range 0..4
CNT_W, 11, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
en  in  1  timing enable
req_valid  out  1  fetch request for an active pixel
req_x  out  CNT_W  requested column
req_y  out  CNT_W  requested row
pix_r  in  CW  red from source, LAT clocks after request
pix_g  in  CW  green from source
pix_b  in  CW  blue from source
red  out  CW  pad red
green  out  CW  pad green
blue  out  CW  pad blue
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
de  out  1  data enable, aligned with rgb
frame_start  out  1  one-clock pulse, aligned with output pixel (0,0)
line_start  out  1  one-clock pulse, aligned with output pixel x=0 of every active line

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- hcnt counts 0..H_TOTAL-1, then wraps to 0.
- vcnt increments on each hcnt wrap and wraps from V_TOTAL-1 to 0. Both counters are registered.
- Active region: hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- hsync region: H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC. vsync region uses the same form in lines; vsync changes only at hcnt==0.
- req_valid, req_x, req_y are registered together with the counters:
  - req_valid = active.
  - req_x = hcnt and req_y = vcnt when active; otherwise 0.
- Source contract: pix_* is valid exactly LAT clocks after the req cycle. LAT=0 means a combinational source.
- Stage-0 flags (hs, vs, de, fs = active&x==0&y==0, ls = active&x==0) pass through a LAT-deep delay line.
- Output register, clocked each edge:
  - rgb <= de_LAT ? pix : 0.
  - hsync, vsync, de, frame_start, line_start <= delayed flags.
  - hsync output = hs_LAT ? HS_POL : ~HS_POL; vsync likewise.
- Total latency from req to pads is LAT+1 clocks, identical for every output.
- Blanking: rgb is 0 whenever de=0, regardless of pix_*.
- en=0:
  - Counters synchronously return to (0,0); req_valid=0.
  - Delay line shifts in inactive flags; outputs drain to blank within LAT+1 clocks.
  - On the next en=1 cycle, counting starts at (0,0), giving a fresh frame and frame_start.
- Reset (async, any time, including mid-frame):
  - Counters and all delay-line stages cleared.
  - red/green/blue=0, de=0, frame_start=0, line_start=0, req_valid=0, req_x=req_y=0.
  - hsync=~HS_POL, vsync=~VS_POL.
  - The first clock after release behaves as an en rise.
- Counter arithmetic is unsigned, CNT_W wide, and never relies on overflow wrap.
- Illegal LAT (>4) or CNT_W too small: elaboration-time error via generate-block check.

Decomposition:
- Shared header vga_timing.vh:
  - Mode presets (640x480@60, 800x600@60, 1024x768@60) as porch/sync/polarity localparam sets.
  - H_TOTAL/V_TOTAL macros.
  - Default CW/CNT_W.
- Sub-module vga_delay_line (params WIDTH, DEPTH, RESET_VAL; async active-low reset; DEPTH=0 is a pass-through). Instantiated once for the 5-bit flag bundle.

Test Plan:
- Reset: assert rst_n=0 mid-line with HS_POL=1 -> outputs immediately red=green=blue=0, de=0, hsync=0, vsync=0, req_valid=0. After release, req (0,0) appears on the first edge.
- Small mode (H 4/1/2/1, V 3/1/1/1, LAT=0) -> line period 8 clocks, frame 48 clocks. hsync high for output cycles 5-6 of each line; vsync high for line 4; de high 4 of 8 clocks on lines 0-2.
- LAT=2 with a model source returning pix_r=x[0], pix_g=y[0], pix_b=x[1] -> every de=1 output equals the pattern for the (x,y) requested 3 clocks earlier; frame_start coincides with the pixel (0,0) output.
- HS_POL=0, VS_POL=0 -> sync outputs idle high and pulse low for the same windows as the positive-polarity case.
- Blanking: drive pix_*=all-ones constantly -> rgb is 0 on every de=0 cycle.
- en dropped for 10 clocks at x=2,y=1 -> pipeline drains to blank within LAT+1 clocks. After en returns, req restarts at (0,0) and frame_start pulses once LAT+1 clocks later.
